// File: rtl/prio_grant_enc.sv
// prio_grant_enc: registered 4-input priority encoder with request buffering.
// Pending requests are held in pend until granted. The grant index on o_idx
// is offered with a valid/ready handshake, and grants can follow each other
// on every cycle.
// Optional build macro PRIO_ENC_RR_EN selects round-robin priority.
// Without it, fixed priority is used and bit 3 is highest.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | nothing offered; the index is loaded from pend_next on each edge
// ST_VALID | o_idx offered and held until the handshake

module prio_grant_enc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_req,
  input  logic       i_clr,
  input  logic       i_idx_rdy,
  output logic [1:0] o_idx,
  output logic       o_idx_vld,
  output logic [3:0] o_pend,
  output logic       o_ovf
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_pend;
  logic [1:0] r_idx;
  logic       r_vld;
  logic       r_ovf;

  logic       w_hs;
  logic [3:0] w_served;
  logic [3:0] w_pend_nx;
  logic       w_ovf_set;
  logic [1:0] w_idx_nx;

`ifdef PRIO_ENC_RR_EN
  logic [1:0] r_last;
  logic [1:0] w_last_nx;

  // Search downward with wrap-around, starting just below lst.
  // This gives lst itself the lowest priority.
  function automatic logic [1:0] f_enc_rr(input logic [3:0] v, input logic [1:0] lst);
    logic [1:0] j;
    logic       found;
    f_enc_rr = 2'd0;
    found    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      j = lst - 2'(k);
      if (!found && v[j]) begin
        f_enc_rr = j;
        found    = 1'b1;
      end
    end
  endfunction
`else
  // Fixed priority: return the highest set bit, or 0 when v is empty.
  function automatic logic [1:0] f_enc_fixed(input logic [3:0] v);
    if (v[3])      f_enc_fixed = 2'd3;
    else if (v[2]) f_enc_fixed = 2'd2;
    else if (v[1]) f_enc_fixed = 2'd1;
    else           f_enc_fixed = 2'd0;
  endfunction
`endif

  // Next-state datapath: served bit, next pend value, overflow detection and next index.
  always_comb begin
    w_hs      = r_vld & i_idx_rdy;
    w_served  = w_hs ? (4'b0001 << r_idx) : 4'b0000;
    w_pend_nx = (r_pend & ~w_served) | i_req;
    w_ovf_set = |(i_req & r_pend & ~w_served);
`ifdef PRIO_ENC_RR_EN
    // Use the pointer as it will be after this edge, so that the grant just
    // made drops to the lowest priority immediately.
    w_last_nx = w_hs ? r_idx : r_last;
    w_idx_nx  = f_enc_rr(w_pend_nx, w_last_nx);
`else
    w_idx_nx  = f_enc_fixed(w_pend_nx);
`endif
  end

  // Grant FSM. pend, the index, valid and the sticky overflow flag are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 4'b0000;
      r_idx   <= 2'd0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
      r_pend  <= 4'b0000;
      r_idx   <= 2'd0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_pend_nx;
      if (w_ovf_set) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_idx   <= w_idx_nx;
          r_vld   <= |w_pend_nx;
          r_state <= (|w_pend_nx) ? ST_VALID : ST_IDLE;
        end
        ST_VALID: begin
          // Hold the index while stalled. A newly arriving higher-priority
          // request only updates pend and does not preempt the offered index.
          if (w_hs) begin
            r_idx   <= w_idx_nx;
            r_vld   <= |w_pend_nx;
            r_state <= (|w_pend_nx) ? ST_VALID : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PRIO_ENC_RR_EN
  // Round-robin pointer: records the most recently granted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= 2'd0;
    else if (i_clr)  r_last <= 2'd0;
    else if (w_hs)   r_last <= r_idx;
  end
`endif

  assign o_idx     = r_idx;
  assign o_idx_vld = r_vld;
  assign o_pend    = r_pend;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_prio_grant_enc.sv
// Bench for prio_grant_enc. It uses directed vectors with hand-computed
// expectations. Expected grant indices go into a queue. A monitor pops an
// entry whenever a handshake is about to occur and compares it with o_idx.
// Register state is checked directly after edges.

module tb_prio_grant_enc;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_req;
  logic       i_clr;
  logic       i_idx_rdy;
  logic [1:0] o_idx;
  logic       o_idx_vld;
  logic [3:0] o_pend;
  logic       o_ovf;

  int         n_pass;
  int         n_total;
  logic [1:0] exp_q[$];
  logic [1:0] exp_g;
  logic [1:0] cont_seq[6];
  logic [1:0] stall_g1;
  logic [1:0] stall_g2;
  logic [3:0] stall_p1;
  logic [3:0] stall_p2;

  prio_grant_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_clr     (i_clr),
    .i_idx_rdy (i_idx_rdy),
    .o_idx     (o_idx),
    .o_idx_vld (o_idx_vld),
    .o_pend    (o_pend),
    .o_ovf     (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Grant monitor. The inputs are stable at the falling edge, so valid & ready
  // seen here means a handshake will occur at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && !i_clr && o_idx_vld && i_idx_rdy) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL grant_unexpected: got idx %0d expected no grant", o_idx);
      end else begin
        exp_g = exp_q.pop_front();
        if (o_idx == exp_g) n_pass++;
        else $display("FAIL grant_idx: got %0d expected %0d", o_idx, exp_g);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
`ifdef PRIO_ENC_RR_EN
    cont_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
    stall_g1 = 2'd0; stall_p1 = 4'b1001;
    stall_g2 = 2'd3; stall_p2 = 4'b1000;
`else
    cont_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    stall_g1 = 2'd3; stall_p1 = 4'b1001;
    stall_g2 = 2'd0; stall_p2 = 4'b0001;
`endif
    rst_n = 1'b0; i_req = 4'b1111; i_clr = 1'b0; i_idx_rdy = 1'b0;

    // Reset holds everything clear even while requests are present.
    tick(); tick();
    chk("rst_vld",  o_idx_vld, 0);
    chk("rst_pend", o_pend, 0);
    chk("rst_ovf",  o_ovf, 0);
    chk("rst_idx",  o_idx, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pend", o_pend, 4'b1111);
    chk("post_rst_idx",  o_idx, 3);
    chk("post_rst_vld",  o_idx_vld, 1);
    i_req = 4'b0000; i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("clr1_pend", o_pend, 0);
    chk("clr1_vld",  o_idx_vld, 0);

    // Stall: the offered index holds while a higher-priority request is only pended.
    i_req = 4'b0101;
    tick();
    chk("stall_idx0", o_idx, 2);
    chk("stall_vld0", o_idx_vld, 1);
    i_req = 4'b1000;
    tick();
    chk("stall_idx1",  o_idx, 2);
    chk("stall_pend1", o_pend, 4'b1101);
    chk("stall_ovf1",  o_ovf, 0);
    i_req = 4'b0000;
    tick();
    chk("stall_idx2", o_idx, 2);
    exp_q.push_back(2'd2);
    exp_q.push_back(stall_g1);
    exp_q.push_back(stall_g2);
    i_idx_rdy = 1'b1;
    tick();
    chk("bb_idx1",  o_idx, stall_g1);
    chk("bb_pend1", o_pend, stall_p1);
    tick();
    chk("bb_idx2",  o_idx, stall_g2);
    chk("bb_pend2", o_pend, stall_p2);
    tick();
    chk("bb_vld_end",  o_idx_vld, 0);
    chk("bb_pend_end", o_pend, 0);
    i_idx_rdy = 1'b0;

    // Overflow: a repeated request for a bit that is pending but not being served.
    i_req = 4'b0010;
    tick();
    chk("ovf_idx",  o_idx, 1);
    chk("ovf_pre",  o_ovf, 0);
    tick();
    chk("ovf_set",  o_ovf, 1);
    chk("ovf_pend", o_pend, 4'b0010);
    i_req = 4'b0000;
    tick();
    chk("ovf_sticky", o_ovf, 1);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("ovf_clr", o_ovf, 0);

    // The same bit requested on its own handshake cycle is pended again without overflow.
    i_req = 4'b0010;
    tick();
    exp_q.push_back(2'd1);
    i_idx_rdy = 1'b1;
    tick();
    i_idx_rdy = 1'b0; i_req = 4'b0000;
    chk("rehs_ovf",  o_ovf, 0);
    chk("rehs_pend", o_pend, 4'b0010);
    chk("rehs_vld",  o_idx_vld, 1);

    // Clear while valid, with a request in the same cycle.
    i_clr = 1'b1; i_req = 4'b0001;
    tick();
    i_clr = 1'b0; i_req = 4'b0000;
    chk("clr_pend", o_pend, 0);
    chk("clr_vld",  o_idx_vld, 0);
    chk("clr_ovf",  o_ovf, 0);
    chk("clr_idx",  o_idx, 0);
    tick();
    chk("clr_stay_pend", o_pend, 0);

    // Asynchronous reset between edges during back-to-back grants.
    i_req = 4'b1111;
    tick();
    i_req = 4'b0000;
    exp_q.push_back(2'd3);
    i_idx_rdy = 1'b1;
    tick();
    chk("arst_pre_idx", o_idx, 2);
    chk("arst_pre_vld", o_idx_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  o_idx_vld, 0);
    chk("arst_pend", o_pend, 0);
    chk("arst_idx",  o_idx, 0);
    chk("arst_ovf",  o_ovf, 0);
    i_idx_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after_vld", o_idx_vld, 0);

    // Continuous requests with the consumer always ready.
    for (int k = 0; k < 6; k++) exp_q.push_back(cont_seq[k]);
    i_req = 4'b1111; i_idx_rdy = 1'b1;
    tick();
    chk("cont_ovf0", o_ovf, 0);
    tick();
    chk("cont_ovf1", o_ovf, 1);
    for (int k = 0; k < 4; k++) tick();
    tick();
    i_idx_rdy = 1'b0; i_req = 4'b0000;
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
